// File: rtl/fp8_add_arbiter.sv
// Two-requester arbiter in front of a shared registered FP8 (1/4/3) adder.
// Define FP8_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module fp8_add_arbiter #(
  parameter int unsigned ADD_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  output logic       req1_ready,
  output logic [7:0] add_a,
  output logic [7:0] add_b,
  output logic       add_ena,
  input  logic [7:0] add_result,
  output logic       resp_valid,
  output logic       resp_id,
  output logic [7:0] resp_data,
  input  logic       resp_ready
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  localparam logic [2:0] LatCnt = 3'(ADD_LATENCY);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] add_a_q, add_a_d;
  logic [7:0] add_b_q, add_b_d;
  logic       resp_id_q, resp_id_d;
  logic [7:0] resp_data_q, resp_data_d;
  logic       grant0, grant1;

`ifndef FP8_ARB_FIXED_PRIO_EN
  logic rr_ptr_q, rr_ptr_d;
`endif

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == StIdle) begin
`ifdef FP8_ARB_FIXED_PRIO_EN
      grant0 = req0_valid;
      grant1 = req1_valid && !req0_valid;
`else
      // rr_ptr only breaks ties; a lone requester always wins
      grant0 = req0_valid && (!req1_valid || !rr_ptr_q);
      grant1 = req1_valid && (!req0_valid || rr_ptr_q);
`endif
    end
  end

`ifndef FP8_ARB_FIXED_PRIO_EN
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant0) begin
      rr_ptr_d = 1'b1;
    end else if (grant1) begin
      rr_ptr_d = 1'b0;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    resp_id_d   = resp_id_q;
    resp_data_d = resp_data_q;
    unique case (state_q)
      StIdle: begin
        if (grant0 || grant1) begin
          add_a_d   = grant1 ? req1_a : req0_a;
          add_b_d   = grant1 ? req1_b : req0_b;
          resp_id_d = grant1;
          cnt_d     = LatCnt;
          state_d   = StWait;
        end
      end
      StWait: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          resp_data_d = add_result;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      add_a_q     <= 8'h00;
      add_b_q     <= 8'h00;
      resp_id_q   <= 1'b0;
      resp_data_q <= 8'h00;
`ifndef FP8_ARB_FIXED_PRIO_EN
      rr_ptr_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      resp_id_q   <= resp_id_d;
      resp_data_q <= resp_data_d;
`ifndef FP8_ARB_FIXED_PRIO_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign add_ena    = (state_q == StWait);
  assign resp_valid = (state_q == StResp);
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;

endmodule
